maxpool_layer: RTL and testbench

- Sequential 1-D max-pooling stage that sits directly downstream of the batch-normalization layer. It consumes that layer's registered serial output stream.
- The stream is organized in frames. A frame is INPUT_SIZE consecutive words, one per channel, channel 0 first.
- For each channel the block takes the signed maximum over POOL_SIZE consecutive frames. It emits one pooled frame of INPUT_SIZE words for every POOL_SIZE input frames, over the same valid-ready handshake.

---
 rtl/maxpool_layer.sv | 98 +++++++++
 tb/tb_maxpool_layer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_layer.sv
// Purpose: 1-D max pooling over POOL_SIZE consecutive frames of INPUT_SIZE
//          signed words; emits one pooled frame per POOL_SIZE input frames.
// Latency: a last-frame word appears on data_r_o one cycle after it is accepted.
// Backpressure: only last-frame words can stall (ready_o low while a result is
//          held unconsumed); earlier frames are accepted whenever valid_i is high.
// Optional: define MAXPOOL_RELU_EN to clamp negative inputs to 0 before pooling.
//
// Ports:
//   clk_i     clock
//   reset_i   synchronous active-high reset
//   valid_i / ready_o / data_r_i   upstream stream (registered signed words)
//   valid_o / ready_i / data_r_o   downstream stream (registered pooled words)
module maxpool_layer #(
   parameter int INPUT_SIZE = 1,
   parameter int POOL_SIZE  = 2,
   parameter int WORD_SIZE  = 16,
   parameter int CH_BITS    = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1,
   parameter int FRAME_BITS = (POOL_SIZE > 1)  ? $clog2(POOL_SIZE)  : 1
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   output logic                        ready_o,
   input  logic                        valid_i,
   input  logic signed [WORD_SIZE-1:0] data_r_i,
   output logic                        valid_o,
   input  logic                        ready_i,
   output logic signed [WORD_SIZE-1:0] data_r_o
);

   localparam logic [CH_BITS-1:0]    CH_LAST    = CH_BITS'(INPUT_SIZE - 1);
   localparam logic [FRAME_BITS-1:0] FRAME_LAST = FRAME_BITS'(POOL_SIZE - 1);

   logic [CH_BITS-1:0]    ch_r;
   logic [FRAME_BITS-1:0] frame_r;

   // Sized to the full counter range so the index never runs past the array.
   logic signed [WORD_SIZE-1:0] max_buf [2**CH_BITS];

   logic                        first;
   logic                        last;
   logic                        in_fire;
   logic                        out_fire;
   logic signed [WORD_SIZE-1:0] din;
   logic signed [WORD_SIZE-1:0] buf_val;
   logic signed [WORD_SIZE-1:0] m;

   assign first    = (frame_r == '0);
   assign last     = (frame_r == FRAME_LAST);

   // Only a last-frame word needs the output register, so only it can stall.
   assign ready_o  = !reset_i && (!last || !valid_o || ready_i);
   assign in_fire  = valid_i && ready_o;
   assign out_fire = valid_o && ready_i;

`ifdef MAXPOOL_RELU_EN
   assign din = data_r_i[WORD_SIZE-1] ? '0 : data_r_i;
`else
   assign din = data_r_i;
`endif

   assign buf_val = max_buf[ch_r];

   // Frame 0 overwrites the buffer, so it never needs a reset; ties keep buf.
   assign m = first ? din : ((din > buf_val) ? din : buf_val);

   always_ff @(posedge clk_i) begin
      if (in_fire && !last) begin
         max_buf[ch_r] <= m;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ch_r     <= '0;
         frame_r  <= '0;
         valid_o  <= 1'b0;
         data_r_o <= '0;
      end else begin
         // Drain first; a same-cycle last-frame accept below re-asserts valid_o.
         if (out_fire) begin
            valid_o <= 1'b0;
         end
         if (in_fire) begin
            if (last) begin
               data_r_o <= m;
               valid_o  <= 1'b1;
            end
            if (ch_r == CH_LAST) begin
               ch_r    <= '0;
               frame_r <= last ? '0 : frame_r + 1'b1;
            end else begin
               ch_r <= ch_r + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_maxpool_layer.sv
// Directed bench for maxpool_layer: a 2-channel/2-frame instance and a
// 2-channel pass-through instance; expected words are queued when driven
// and compared in order when the DUT hands them downstream.
module tb_maxpool_layer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // 2 channels, pool of 2
   logic               a_rdy_o, a_vld_o;
   logic               a_vld = 1'b0, a_rdy = 1'b0;
   logic signed [15:0] a_dat = '0;
   logic signed [15:0] a_dat_o;

   // 2 channels, pool of 1 (pass-through)
   logic               p_rdy_o, p_vld_o;
   logic               p_vld = 1'b0, p_rdy = 1'b0;
   logic signed [15:0] p_dat = '0;
   logic signed [15:0] p_dat_o;

   logic signed [15:0] q_a[$];
   logic signed [15:0] q_p[$];

   int total = 0;
   int bad   = 0;

   maxpool_layer #(.INPUT_SIZE(2), .POOL_SIZE(2), .WORD_SIZE(16)) dut_a (
      .clk_i(clk), .reset_i(rst),
      .ready_o(a_rdy_o), .valid_i(a_vld), .data_r_i(a_dat),
      .valid_o(a_vld_o), .ready_i(a_rdy), .data_r_o(a_dat_o)
   );

   maxpool_layer #(.INPUT_SIZE(2), .POOL_SIZE(1), .WORD_SIZE(16)) dut_p (
      .clk_i(clk), .reset_i(rst),
      .ready_o(p_rdy_o), .valid_i(p_vld), .data_r_i(p_dat),
      .valid_o(p_vld_o), .ready_i(p_rdy), .data_r_o(p_dat_o)
   );

   // Expected effect of the optional input clamp on a pooled value.
   function automatic logic signed [15:0] r(input logic signed [15:0] x);
`ifdef MAXPOOL_RELU_EN
      return x[15] ? 16'sd0 : x;
`else
      return x;
`endif
   endfunction

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_word(input string tag, input logic signed [15:0] obs,
                           input logic signed [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: at the falling edge, any word about to be handed downstream
   // is popped against the scoreboard; inputs change 1 time unit after the rise.
   task automatic tick();
      @(negedge clk);
      if (a_vld_o && a_rdy) begin
         total++;
         assert (q_a.size() > 0) else begin
            bad++;
            $error("FAIL a_extra: got output %0d expected none", a_dat_o);
         end
         if (q_a.size() > 0) chk_word("a_out", a_dat_o, q_a.pop_front());
      end
      if (p_vld_o && p_rdy) begin
         total++;
         assert (q_p.size() > 0) else begin
            bad++;
            $error("FAIL p_extra: got output %0d expected none", p_dat_o);
         end
         if (q_p.size() > 0) chk_word("p_out", p_dat_o, q_p.pop_front());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_a(input int v);
      a_vld = 1'b1;
      a_dat = 16'(v);
   endtask

   task automatic push_a(input int v);
      q_a.push_back(r(16'(v)));
   endtask

   int pvals[8] = '{32767, -32768, -1, 0, 5, -6, 100, -100};

   initial begin
      // ---------------- reset ----------------
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk_bit ("rst_vld",  a_vld_o, 1'b0);
      chk_word("rst_dat",  a_dat_o, 16'sd0);
      chk_bit ("rst_rdy",  a_rdy_o, 1'b0);
      chk_bit ("rst_prdy", p_rdy_o, 1'b0);
      rst = 1'b0;
      #1;
      chk_bit ("post_rst_rdy", a_rdy_o, 1'b1);

      // ---------------- basic pooling: 3,-5,7,-2 -> 7,-2 ----------------
      a_rdy = 1'b1;
      send_a(3);  tick();
      send_a(-5); tick();
      send_a(7);  push_a(7); tick();
      chk_bit ("lat_ch0_vld", a_vld_o, 1'b1);
      chk_word("lat_ch0_dat", a_dat_o, 16'sd7);
      send_a(-2); push_a(-2); tick();
      chk_bit ("lat_ch1_vld", a_vld_o, 1'b1);
      chk_word("lat_ch1_dat", a_dat_o, r(-16'sd2));
      a_vld = 1'b0; tick();
      chk_bit ("basic_idle_vld", a_vld_o, 1'b0);

      // ---------------- back-pressure ----------------
      send_a(3);  tick();
      send_a(-5); tick();
      send_a(7);  push_a(7); tick();
      a_rdy = 1'b0;
      send_a(-2); push_a(-2);
      #1;
      chk_bit ("bp_last_rdy", a_rdy_o, 1'b0);
      tick(); tick();
      chk_word("bp_hold_dat", a_dat_o, 16'sd7);
      chk_bit ("bp_hold_vld", a_vld_o, 1'b1);
      a_rdy = 1'b1; tick();            // 7 leaves, -2 enters
      a_rdy = 1'b0;
      send_a(10);
      #1;
      chk_bit ("bp_f0_rdy", a_rdy_o, 1'b1);
      tick();
      send_a(20); tick();
      send_a(1);  push_a(10);
      #1;
      chk_bit ("bp_f1_rdy", a_rdy_o, 1'b0);
      tick(); tick();
      chk_word("bp_hold2_dat", a_dat_o, r(-16'sd2));
      a_rdy = 1'b1; tick();
      send_a(30); push_a(30); tick();
      a_vld = 1'b0; tick();
      tick();
      chk_bit ("bp_idle_vld", a_vld_o, 1'b0);

      // ---------------- mid-window reset ----------------
      a_rdy = 1'b0;
      send_a(50); tick();
      send_a(60); tick();
      send_a(70); tick();              // result left unconsumed, then discarded
      a_vld = 1'b0;
      rst = 1'b1;
      #1;
      chk_bit ("mid_rst_rdy", a_rdy_o, 1'b0);
      tick();
      rst = 1'b0;
      #1;
      chk_bit ("mid_rst_vld", a_vld_o, 1'b0);
      chk_word("mid_rst_dat", a_dat_o, 16'sd0);
      a_rdy = 1'b1;
      send_a(1); tick();
      send_a(2); tick();
      send_a(4); push_a(4); tick();
      send_a(0); push_a(2); tick();
      a_vld = 1'b0; tick();

      // ---------------- all-negative window ----------------
      send_a(-8); tick();
      send_a(-3); tick();
      send_a(-1); push_a(-1); tick();
`ifdef MAXPOOL_RELU_EN
      chk_word("neg_ch0", a_dat_o, 16'sd0);
`else
      chk_word("neg_ch0", a_dat_o, -16'sd1);
`endif
      send_a(-9); push_a(-3); tick();
`ifdef MAXPOOL_RELU_EN
      chk_word("neg_ch1", a_dat_o, 16'sd0);
`else
      chk_word("neg_ch1", a_dat_o, -16'sd3);
`endif
      a_vld = 1'b0; tick();

      // ---------------- pass-through, continuous stream ----------------
      p_rdy = 1'b1;
      p_vld = 1'b1;
      for (int i = 0; i < 8; i++) begin
         p_dat = 16'(pvals[i]);
         q_p.push_back(r(16'(pvals[i])));
         #1;
         chk_bit("pt_rdy", p_rdy_o, 1'b1);
         tick();
         chk_bit ("pt_vld", p_vld_o, 1'b1);
         chk_word("pt_dat", p_dat_o, r(16'(pvals[i])));
      end
      p_vld = 1'b0; tick();
      tick();
      chk_bit("pt_idle_vld", p_vld_o, 1'b0);

      // Nothing queued may be left undelivered.
      total++;
      assert (q_a.size() == 0) else begin
         bad++;
         $error("FAIL a_leftover: got %0d pending expected 0", q_a.size());
      end
      total++;
      assert (q_p.size() == 0) else begin
         bad++;
         $error("FAIL p_leftover: got %0d pending expected 0", q_p.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
